// File: rtl/s1_rs_syndrome_calc.sv
// Stage-1 RS(255,239) syndrome calculator over GF(2^8), poly 0x11D.
// Horner-accumulates S_i = r(alpha^i), i=0..NSYN-1, one symbol per valid cycle.
module s1_rs_syndrome_calc #(
   parameter int N    = 255,
   parameter int NSYN = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic              in_sop,
   input  logic [7:0]        in_data,
   output logic              syn_valid,
   output logic [8*NSYN-1:0] syn,
   output logic              err_flag,
   output logic              sop_err
);

   localparam logic [7:0] LAST = 8'(N - 1);

   typedef enum logic {IDLE, ACC} state_t;

   state_t                 state, state_nxt;
   logic                   load, step, done, restart;
   logic [7:0]             sym_cnt;
   logic [NSYN-1:0][7:0]   acc, acc_upd;

   function automatic logic [7:0] mul_alpha(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
   endfunction

   // p is a per-lane constant, so this unrolls into a fixed XOR network.
   function automatic logic [7:0] mul_alpha_pow(input logic [7:0] a, input int p);
      logic [7:0] r;
      r = a;
      for (int k = 0; k < p; k++) r = mul_alpha(r);
      return r;
   endfunction

   for (genvar g = 0; g < NSYN; g++) begin : g_lane
      assign acc_upd[g] = mul_alpha_pow(acc[g], g) ^ in_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      done      = 1'b0;
      restart   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_sop) begin
               load      = 1'b1;
               state_nxt = ACC;
            end
         end
         ACC: begin
            if (in_valid) begin
               if (in_sop) begin
                  // a sop always wins, even on what would have been the last symbol
                  load    = 1'b1;
                  restart = 1'b1;
               end else if (sym_cnt == LAST) begin
                  step      = 1'b1;
                  done      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc       <= '0;
         sym_cnt   <= '0;
         syn       <= '0;
         err_flag  <= 1'b0;
         syn_valid <= 1'b0;
         sop_err   <= 1'b0;
      end else begin
         syn_valid <= done;
         sop_err   <= restart;
         if (load) begin
            acc     <= {NSYN{in_data}};
            sym_cnt <= 8'd1;
         end else if (step) begin
            acc     <= acc_upd;
            sym_cnt <= sym_cnt + 8'd1;
         end
         if (done) begin
            syn      <= acc_upd;
            err_flag <= |acc_upd;
         end
      end
   end

endmodule

// File: tb/tb_s1_rs_syndrome_calc.sv
// Directed bench for s1_rs_syndrome_calc: hand-computed syndromes plus an
// encoder-built valid codeword; checks latency, restart and reset behaviour.
module tb_s1_rs_syndrome_calc;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_sop = 1'b0;
   logic [7:0]   in_data = 8'h00;
   logic         syn_valid, err_flag, sop_err;
   logic [127:0] syn;

   s1_rs_syndrome_calc #(.N(255), .NSYN(16)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
      .syn_valid(syn_valid), .syn(syn), .err_flag(err_flag), .sop_err(sop_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_err = 0;
   int n_val = 0, n_serr = 0, n_both = 0, serr_cyc = 0;
   logic [127:0] syn_q[$];
   logic         err_q[$];
   int           vcyc_q[$];

   always @(negedge clk) begin
      if (syn_valid) begin
         n_val++;
         syn_q.push_back(syn);
         err_q.push_back(err_flag);
         vcyc_q.push_back(cyc);
      end
      if (sop_err) begin
         n_serr++;
         serr_cyc = cyc;
      end
      if (syn_valid && sop_err) n_both++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // alpha^(254*i) = alpha^(-i), i = 0..15
   logic [7:0]   ainv[16] = '{8'h01, 8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36, 8'h1B,
                              8'h83, 8'hCF, 8'hE9, 8'hFA, 8'h7D, 8'hB0, 8'h58, 8'h2C};
   logic [127:0] exp_inv;
   logic [127:0] all_5a;

   logic [7:0] frame[255];
   int         first_cyc = 0;

   task automatic put(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      in_valid = v;
      in_sop   = s;
      in_data  = d;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) put(1'b0, 1'b0, 8'h00);
   endtask

   task automatic clear_frame();
      for (int k = 0; k < 255; k++) frame[k] = 8'h00;
   endtask

   task automatic send_frame(input int gap_pct);
      for (int k = 0; k < 255; k++) begin
         if (k > 0) begin
            int g = 0;
            while (g < 8 && int'($urandom_range(99)) < gap_pct) begin
               put(1'b0, 1'b0, 8'h00);
               g++;
            end
         end
         put(1'b1, k == 0, frame[k]);
         if (k == 0) first_cyc = cyc;
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, x;
      r = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) r ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return r;
   endfunction

   logic [7:0] gpoly[17];
   logic [7:0] cw[255];
   int         mdeg[4] = '{0, 5, 100, 238};
   logic [7:0] mval[4] = '{8'h37, 8'hC1, 8'h02, 8'h99};

   initial begin
      int v0, s0, rc;
      logic [7:0] root;

      for (int i = 0; i < 16; i++) begin
         exp_inv[8*i +: 8] = ainv[i];
         all_5a[8*i +: 8]  = 8'h5A;
      end

      // reset state
      repeat (2) @(negedge clk);
      check("rst_syn", syn, '0);
      check("rst_err", err_flag, 0);
      check("rst_valid", syn_valid, 0);
      check("rst_soperr", sop_err, 0);
      rstn = 1'b1;

      // 1: all-zero codeword, back-to-back
      clear_frame();
      v0 = n_val;
      send_frame(0);
      idle(3);
      check("t1_count", n_val - v0, 1);
      check("t1_syn", syn_q[$], '0);
      check("t1_err", err_q[$], 0);
      check("t1_latency", vcyc_q[$] - first_cyc, 255);

      // 2: single 0x01 at the highest degree
      clear_frame();
      frame[0] = 8'h01;
      v0 = n_val;
      send_frame(0);
      idle(3);
      check("t2_count", n_val - v0, 1);
      check("t2_syn", syn_q[$], exp_inv);
      check("t2_err", err_q[$], 1);

      // 3: 0x5A as the constant term, then an all-zero frame with no gap
      clear_frame();
      frame[254] = 8'h5A;
      v0 = n_val;
      send_frame(0);
      clear_frame();
      send_frame(0);
      idle(3);
      check("t3_count", n_val - v0, 2);
      check("t3_syn_a", syn_q[$-1], all_5a);
      check("t3_err_a", err_q[$-1], 1);
      check("t3_syn_b", syn_q[$], '0);
      check("t3_err_b", err_q[$], 0);
      check("t3_spacing", vcyc_q[$] - vcyc_q[$-1], 255);

      // 4: valid codeword m(x)*g(x) with random gaps
      for (int j = 0; j < 17; j++) gpoly[j] = (j == 0) ? 8'h01 : 8'h00;
      root = 8'h01;
      for (int i = 0; i < 16; i++) begin
         for (int j = 16; j >= 1; j--) gpoly[j] = gpoly[j-1] ^ gmul(gpoly[j], root);
         gpoly[0] = gmul(gpoly[0], root);
         root = gmul(root, 8'h02);
      end
      for (int k = 0; k < 255; k++) cw[k] = 8'h00;
      for (int t = 0; t < 4; t++)
         for (int j = 0; j < 17; j++) cw[mdeg[t] + j] ^= gmul(mval[t], gpoly[j]);
      for (int k = 0; k < 255; k++) frame[k] = cw[254 - k];
      v0 = n_val;
      send_frame(30);
      idle(3);
      check("t4_count", n_val - v0, 1);
      check("t4_syn", syn_q[$], '0);
      check("t4_err", err_q[$], 0);

      // 5: sop at symbol 100 restarts, restarted frame is the 0x01 pattern
      v0 = n_val;
      s0 = n_serr;
      put(1'b1, 1'b1, 8'h33);
      for (int k = 1; k < 99; k++) put(1'b1, 1'b0, 8'(k * 7 + 1));
      clear_frame();
      frame[0] = 8'h01;
      send_frame(0);
      idle(3);
      check("t5_soperr_count", n_serr - s0, 1);
      check("t5_soperr_time", serr_cyc - first_cyc, 1);
      check("t5_count", n_val - v0, 1);
      check("t5_syn", syn_q[$], exp_inv);

      // 6: reset at symbol 200, then sop-less symbols are dropped
      v0 = n_val;
      put(1'b1, 1'b1, 8'h11);
      for (int k = 1; k < 199; k++) put(1'b1, 1'b0, 8'h22);
      @(negedge clk);
      rstn = 1'b0;
      in_valid = 1'b1;
      in_sop = 1'b0;
      in_data = 8'h77;
      @(negedge clk);
      rstn = 1'b1;
      in_valid = 1'b0;
      check("t6_rst_syn", syn, '0);
      check("t6_rst_err", err_flag, 0);
      check("t6_rst_valid", syn_valid, 0);
      check("t6_rst_soperr", sop_err, 0);
      for (int k = 0; k < 60; k++) put(1'b1, 1'b0, 8'h5A);
      idle(3);
      check("t6_dropped", n_val - v0, 0);
      clear_frame();
      frame[254] = 8'h5A;
      send_frame(0);
      idle(3);
      check("t6_count", n_val - v0, 1);
      check("t6_syn", syn_q[$], all_5a);

      // 7: sop on the last symbol restarts instead of completing
      v0 = n_val;
      s0 = n_serr;
      put(1'b1, 1'b1, 8'h42);
      for (int k = 1; k < 254; k++) put(1'b1, 1'b0, 8'h10);
      put(1'b1, 1'b1, 8'h01);
      rc = cyc;
      for (int k = 0; k < 254; k++) put(1'b1, 1'b0, 8'h00);
      idle(3);
      check("t7_soperr_count", n_serr - s0, 1);
      check("t7_soperr_time", serr_cyc - rc, 1);
      check("t7_count", n_val - v0, 1);
      check("t7_syn", syn_q[$], exp_inv);
      check("t7_err", err_q[$], 1);

      check("no_overlap", n_both, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
